// File: rtl/sincos_nco_if.sv
// sincos_nco_if: control, configuration-write and sample-output bundle of the
// sincos_nco oscillator.
//   master : drives en, sync, frq_we, ofs_we, wr_ch, wr_data;
//            receives sin, cos, out_ch, out_valid
//   slave  : the oscillator side of the same signals
// CW is derived from NCH and must not be overridden.
interface sincos_nco_if #(
   parameter int NCH = 4,
   parameter int FSZ = 24,
   parameter int OSZ = 18
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic           en;
   logic           sync;
   logic           frq_we;
   logic           ofs_we;
   logic [CW-1:0]  wr_ch;
   logic [FSZ-1:0] wr_data;
   logic [OSZ-1:0] sin;
   logic [OSZ-1:0] cos;
   logic [CW-1:0]  out_ch;
   logic           out_valid;

   modport master (
      output en, sync, frq_we, ofs_we, wr_ch, wr_data,
      input  sin, cos, out_ch, out_valid
   );

   modport slave (
      input  en, sync, frq_we, ofs_we, wr_ch, wr_data,
      output sin, cos, out_ch, out_valid
   );
endinterface

// File: rtl/sincos_nco.sv
// sincos_nco: multi-channel time-multiplexed quadrature NCO.
// One phase accumulator, frequency word and phase offset per channel; one
// channel slot is issued per clock with en=1, round-robin. The truncated phase
// is folded into a quarter wave and looked up in two sc_lut instances.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : sincos_nco_if.slave (en, sync, frq_we, ofs_we, wr_ch, wr_data
//              in; sin, cos, out_ch, out_valid out)
// Latency: a slot issued at edge t is presented after edge t+4.
module sincos_nco #(
   parameter int NCH = 4,
   parameter int FSZ = 24,
   parameter int PSZ = 12,
   parameter int OSZ = 18
) (
   input logic         clk,
   input logic         reset_n,
   sincos_nco_if.slave bus
);
   localparam int              CW      = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int              ASZ     = PSZ - 2;
   localparam logic [CW:0]     NCH_W   = (CW+1)'(NCH);
   localparam logic [CW-1:0]   LAST_CH = CW'(NCH - 32'sd1);
   localparam logic [PSZ-1:0]  QTR     = {{(PSZ-1){1'b0}}, 1'b1} << (PSZ-2);

   // two's complement negation of a LUT magnitude
   function automatic logic [OSZ-1:0] twos_neg(input logic [OSZ-1:0] v);
      return (~v) + {{(OSZ-1){1'b0}}, 1'b1};
   endfunction

   logic [FSZ-1:0] acc_r [NCH];
   logic [FSZ-1:0] frq_r [NCH];
   logic [FSZ-1:0] ofs_r [NCH];
   logic [CW-1:0]  cnt_r;
   logic [CW-1:0]  cnt_nxt_s;
   logic           issue_s;
   logic           wr_ok_s;
   logic [FSZ-1:0] ph_sum_s;

   // issue stage
   logic           iss_v_r;
   logic [CW-1:0]  iss_ch_r;
   logic [PSZ-1:0] iss_ph_r;

   // stage 0: folded addresses and sign bits
   logic [PSZ-1:0] cph_s;
   logic [ASZ-1:0] sa_s;
   logic [ASZ-1:0] ca_s;
   logic           s0_v_r;
   logic [CW-1:0]  s0_ch_r;
   logic [ASZ-1:0] s0_sa_r;
   logic [ASZ-1:0] s0_ca_r;
   logic           s0_sdi_r;
   logic           s0_cdi_r;

   // side-band delayed alongside the LUT's two internal stages
   logic           l1_v_r,   l2_v_r;
   logic [CW-1:0]  l1_ch_r,  l2_ch_r;
   logic           l1_sdi_r, l2_sdi_r;
   logic           l1_cdi_r, l2_cdi_r;
   logic [OSZ-1:0] sin_lut_s;
   logic [OSZ-1:0] cos_lut_s;

   // issue qualification, write-range check, next channel and slot phase
   always_comb begin
      issue_s  = bus.en & ~bus.sync;
      wr_ok_s  = ({1'b0, bus.wr_ch} < NCH_W);
      ph_sum_s = acc_r[cnt_r] + ofs_r[cnt_r];
      if (cnt_r == LAST_CH) begin
         cnt_nxt_s = '0;
      end else begin
         cnt_nxt_s = cnt_r + 1'b1;
      end
   end

   // the fractional phase bits below the lookup phase are intentionally dropped
   if (FSZ > PSZ) begin : g_trunc
      logic unused_ph_s;
      assign unused_ph_s = ^ph_sum_s[FSZ-PSZ-1:0];
   end

   // accumulators and channel counter; sync wins over the en-driven update
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) acc_r[i] <= '0;
         cnt_r <= '0;
      end else if (bus.sync) begin
         for (int i = 0; i < NCH; i++) acc_r[i] <= '0;
         cnt_r <= '0;
      end else if (bus.en) begin
         acc_r[cnt_r] <= acc_r[cnt_r] + frq_r[cnt_r];
         cnt_r        <= cnt_nxt_s;
      end
   end

   // frequency / offset word writes; the issuing slot already read the old value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            frq_r[i] <= '0;
            ofs_r[i] <= '0;
         end
      end else begin
         if (bus.frq_we && wr_ok_s) frq_r[bus.wr_ch] <= bus.wr_data;
         if (bus.ofs_we && wr_ok_s) ofs_r[bus.wr_ch] <= bus.wr_data;
      end
   end

   // issue register: truncated lookup phase of the slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         iss_v_r  <= 1'b0;
         iss_ch_r <= '0;
         iss_ph_r <= '0;
      end else begin
         iss_v_r  <= issue_s;
         iss_ch_r <= cnt_r;
         iss_ph_r <= ph_sum_s[FSZ-1 -: PSZ];
      end
   end

   // quarter-wave folding: bit PSZ-2 mirrors the address, bit PSZ-1 flips the sign
   always_comb begin
      cph_s = iss_ph_r + QTR;
      sa_s  = iss_ph_r[ASZ-1:0] ^ {ASZ{iss_ph_r[PSZ-2]}};
      ca_s  = cph_s[ASZ-1:0] ^ {ASZ{cph_s[PSZ-2]}};
   end

   // stage 0 register: LUT addresses and data-invert bits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s0_v_r   <= 1'b0;
         s0_ch_r  <= '0;
         s0_sa_r  <= '0;
         s0_ca_r  <= '0;
         s0_sdi_r <= 1'b0;
         s0_cdi_r <= 1'b0;
      end else begin
         s0_v_r   <= iss_v_r;
         s0_ch_r  <= iss_ch_r;
         s0_sa_r  <= sa_s;
         s0_ca_r  <= ca_s;
         s0_sdi_r <= iss_ph_r[PSZ-1];
         s0_cdi_r <= cph_s[PSZ-1];
      end
   end

   sc_lut #(.ASZ(ASZ), .DSZ(OSZ)) u_sin_lut (
      .clk(clk), .reset_n(reset_n), .addr(s0_sa_r), .data(sin_lut_s)
   );

   sc_lut #(.ASZ(ASZ), .DSZ(OSZ)) u_cos_lut (
      .clk(clk), .reset_n(reset_n), .addr(s0_ca_r), .data(cos_lut_s)
   );

   // delay valid, channel and invert bits to line up with the LUT data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         l1_v_r   <= 1'b0;
         l2_v_r   <= 1'b0;
         l1_ch_r  <= '0;
         l2_ch_r  <= '0;
         l1_sdi_r <= 1'b0;
         l2_sdi_r <= 1'b0;
         l1_cdi_r <= 1'b0;
         l2_cdi_r <= 1'b0;
      end else begin
         l1_v_r   <= s0_v_r;
         l2_v_r   <= l1_v_r;
         l1_ch_r  <= s0_ch_r;
         l2_ch_r  <= l1_ch_r;
         l1_sdi_r <= s0_sdi_r;
         l2_sdi_r <= l1_sdi_r;
         l1_cdi_r <= s0_cdi_r;
         l2_cdi_r <= l1_cdi_r;
      end
   end

   // output register; samples hold between valid slots
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.sin       <= '0;
         bus.cos       <= '0;
         bus.out_ch    <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= l2_v_r;
         if (l2_v_r) begin
            bus.sin    <= l2_sdi_r ? twos_neg(sin_lut_s) : sin_lut_s;
            bus.cos    <= l2_cdi_r ? twos_neg(cos_lut_s) : cos_lut_s;
            bus.out_ch <= l2_ch_r;
         end
      end
   end
endmodule

// sc_lut: quarter-wave sine ROM with a fixed 2-cycle latency.
// Entry a = round((2^(DSZ-1)-1) * sin(pi/2 * (a+0.5) / 2^ASZ)); the half-LSB
// address offset keeps the table symmetric so mirroring needs no correction.
// Ports: clk, reset_n (async active-low), addr (ASZ), data (DSZ, unsigned).
module sc_lut #(
   parameter int ASZ = 10,
   parameter int DSZ = 18
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [ASZ-1:0] addr,
   output logic [DSZ-1:0] data
);
   localparam int  DEPTH = 1 << ASZ;
   localparam real PI    = 3.14159265358979323846;
   localparam real AMP   = (2.0 ** (DSZ - 1)) - 1.0;

   logic [DSZ-1:0] rom_s [DEPTH];
   logic [DSZ-1:0] rd_r;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam real ANG = PI / 2.0 * (real'(gi) + 0.5) / real'(DEPTH);
      localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
      assign rom_s[gi] = DSZ'(VAL);
   end

   // ROM read register followed by the output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_r <= '0;
         data <= '0;
      end else begin
         rd_r <= rom_s[addr];
         data <= rd_r;
      end
   end
endmodule
